// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//
// Answers the hazard unit's divider handshake: EX stalls on
// start & ~ready, and this block raises ready once {remainder, quotient}
// is valid. A finished result is held while the downstream stall is high
// and is handed over exactly once. annul (exception flush) abandons any
// operation in flight.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous, active-high reset
//   start      in   1         a DIV/DIVU occupies EX and requests a result
//   signed_div in   1         1 = DIV (signed), 0 = DIVU
//   annul      in   1         exception flush; returns to IDLE
//   stall      in   1         downstream stall; EX cannot advance
//   opdata1    in   DATA_W    dividend
//   opdata2    in   DATA_W    divisor
//   result     out  2*DATA_W  {remainder (HI), quotient (LO)}
//   ready      out  1         result valid (state DONE)
//   busy       out  1         dividing (state BUSY or DZERO)
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic                annul,
    input  logic                stall,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DZERO = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Magnitude of a two's-complement operand; raw value for unsigned ops.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic              sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] result_q;
    logic                sgn_quo_q;
    logic                sgn_rem_q;

    // Iteration datapath; only meaningful while BUSY, so left without reset.
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvsr_q;

    logic [DATA_W:0]     shl_rem;
    logic [DATA_W:0]     trial;
    logic                step_ok;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
    logic [DATA_W-1:0]   rem_fin;
    logic [DATA_W-1:0]   quo_fin;
    logic                last_iter;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor. Because rem < divisor, the
    // (DATA_W+1)-bit difference has its MSB set exactly when it went negative.
    always_comb begin
        shl_rem  = {rem_q, quo_q[DATA_W-1]};
        trial    = shl_rem - {1'b0, dvsr_q};
        step_ok  = ~trial[DATA_W];
        rem_step = step_ok ? trial[DATA_W-1:0] : shl_rem[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], step_ok};
        // Truncating division: quotient sign from both operands, remainder
        // sign follows the dividend.
        quo_fin  = sgn_quo_q ? -quo_step : quo_step;
        rem_fin  = sgn_rem_q ? -rem_step : rem_step;
        last_iter = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
        end else if (annul) begin
            // Flush wins over everything; result is left untouched.
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (opdata2 == '0) begin
                            state_q <= DZERO;
                        end else begin
                            state_q   <= BUSY;
                            cnt_q     <= '0;
                            sgn_quo_q <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                            sgn_rem_q <= signed_div & opdata1[DATA_W-1];
                        end
                    end
                end
                DZERO: begin
                    // Architecturally undefined; this unit returns zero.
                    state_q  <= DONE;
                    result_q <= '0;
                end
                BUSY: begin
                    if (!start) begin
                        // Instruction left EX without a flush: abort.
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (last_iter) begin
                            state_q  <= DONE;
                            result_q <= {rem_fin, quo_fin};
                        end
                    end
                end
                DONE: begin
                    // Always leave DONE once consumed so a following divide
                    // never sees a stale ready.
                    if (!stall) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operands are captured only on the IDLE->BUSY edge.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start && !annul) begin
            rem_q  <= '0;
            quo_q  <= abs_val(opdata1, signed_div);
            dvsr_q <= abs_val(opdata2, signed_div);
        end else if (state_q == BUSY) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
        end
    end

    assign result = result_q;
    assign ready  = (state_q == DONE);
    assign busy   = (state_q == BUSY) || (state_q == DZERO);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .annul(annul), .stall(stall), .opdata1(opdata1), .opdata2(opdata2),
        .result(result), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit integer division (truncating toward zero).
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one divide starting in the current cycle (called #1 after a
    // posedge with the DUT idle). Scrambles operands after the first cycle,
    // drops start once ready has been seen, runs a fixed 40-cycle window.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int first, output int nrdy, output logic [63:0] res);
        first = -1;
        nrdy  = 0;
        res   = '0;
        start = 1'b1; opdata1 = a; opdata2 = b; signed_div = s;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) begin
                nrdy++;
                if (first < 0) begin
                    first = c;
                    res   = result;
                end
            end
            @(posedge clk); #1;
            if (first >= 0) start = 1'b0;
            else begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (result !== 64'd0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", result); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int first, nrdy; logic [63:0] res;
        run_op(32'd100, 32'd7, 1'b0, first, nrdy, res);
        n_checks++; if (first !== 33) begin n_errors++; $display("FAIL divu_latency: got %0d expected 33", first); end
        n_checks++; if (nrdy !== 1) begin n_errors++; $display("FAIL divu_ready_cycles: got %0d expected 1", nrdy); end
        n_checks++; if (res !== 64'h00000002_0000000E) begin n_errors++; $display("FAIL divu_result: got %h expected 000000020000000e", res); end
        n_checks++; if (busy !== 1'b0 || ready !== 1'b0) begin n_errors++; $display("FAIL divu_idle_after: got busy=%b ready=%b expected 0 0", busy, ready); end
    endtask

    task automatic test_signed();
        int first, nrdy; logic [63:0] res;
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, first, nrdy, res);
        n_checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD || res !== ref_div(32'hFFFFFFF9, 32'd2, 1'b1)) begin n_errors++; $display("FAIL div_neg7_by_2: got %h expected fffffffffffffffd", res); end
        run_op(32'hFFFFFFFF, 32'd2, 1'b0, first, nrdy, res);
        n_checks++; if (res !== 64'h00000001_7FFFFFFF) begin n_errors++; $display("FAIL divu_max_by_2: got %h expected 000000017fffffff", res); end
    endtask

    task automatic test_overflow_dz();
        int first, nrdy; logic [63:0] res;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, first, nrdy, res);
        n_checks++; if (res !== 64'h00000000_80000000) begin n_errors++; $display("FAIL div_overflow: got %h expected 0000000080000000", res); end
        for (int s = 0; s < 2; s++) begin
            run_op(32'd5, 32'd0, s[0], first, nrdy, res);
            n_checks++; if (first !== 2) begin n_errors++; $display("FAIL dz_latency s=%0d: got %0d expected 2", s, first); end
            n_checks++; if (res !== 64'd0) begin n_errors++; $display("FAIL dz_result s=%0d: got %h expected 0", s, res); end
        end
    endtask

    task automatic test_annul();
        int first, nrdy; logic [63:0] res;
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL annul_ready c=%0d: got %b expected 0", c, ready); end
            n_checks++; if (busy !== (c >= 1 && c <= 10)) begin n_errors++; $display("FAIL annul_busy c=%0d: got %b expected %b", c, busy, (c >= 1 && c <= 10)); end
            @(posedge clk); #1;
            if (c == 9) annul = 1'b1;
            if (c == 10) begin annul = 1'b0; start = 1'b0; end
        end
        // Now in cycle 12: new DIVU 9/3, ready expected at cycle 45 overall.
        run_op(32'd9, 32'd3, 1'b0, first, nrdy, res);
        n_checks++; if (first + 12 !== 45) begin n_errors++; $display("FAIL annul_restart_latency: got %0d expected 45", first + 12); end
        n_checks++; if (res !== 64'h00000000_00000003) begin n_errors++; $display("FAIL annul_restart_result: got %h expected 3", res); end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        logic        exp_rdy;
        exp = ref_div(32'd100, 32'd7, 1'b0);
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        for (int c = 0; c < 39; c++) begin
            @(negedge clk);
            exp_rdy = (c >= 33 && c <= 37);
            n_checks++; if (ready !== exp_rdy) begin n_errors++; $display("FAIL stall_ready c=%0d: got %b expected %b", c, ready, exp_rdy); end
            if (exp_rdy) begin
                n_checks++; if (result !== exp) begin n_errors++; $display("FAIL stall_result c=%0d: got %h expected %h", c, result, exp); end
            end
            if (c == 38) begin
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stall_idle_after: got busy=%b expected 0", busy); end
            end
            @(posedge clk); #1;
            stall = (c + 1 >= 33 && c + 1 <= 36);
            if (c + 1 == 38) start = 1'b0;
        end
        stall = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        for (int c = 0; c < 69; c++) begin
            @(negedge clk);
            exp_rdy = (c == 33 || c == 67);
            n_checks++; if (ready !== exp_rdy) begin n_errors++; $display("FAIL b2b_ready c=%0d: got %b expected %b", c, ready, exp_rdy); end
            if (c == 33) begin
                n_checks++; if (result !== ref_div(32'd100, 32'd7, 1'b0)) begin n_errors++; $display("FAIL b2b_first_result: got %h expected %h", result, ref_div(32'd100, 32'd7, 1'b0)); end
            end
            if (c == 34) begin
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy); end
            end
            if (c == 67) begin
                n_checks++; if (result !== 64'h00000000_0000000A) begin n_errors++; $display("FAIL b2b_second_result: got %h expected a", result); end
            end
            @(posedge clk); #1;
            if (c + 1 == 34) begin opdata1 = 32'd50; opdata2 = 32'd5; end
            if (c + 1 == 68) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL abort_ready c=%0d: got %b expected 0", c, ready); end
            if (c == 16) begin
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
            end
            @(posedge clk); #1;
            if (c + 1 == 15) start = 1'b0;
        end
        // Third divide, reset asserted mid-BUSY.
        start = 1'b1; opdata1 = 32'd123; opdata2 = 32'd4;
        repeat (10) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || ready !== 1'b0) begin n_errors++; $display("FAIL rst_async_flags: got busy=%b ready=%b expected 0 0", busy, ready); end
        n_checks++; if (result !== 64'd0) begin n_errors++; $display("FAIL rst_async_result: got %h expected 0", result); end
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int first, nrdy, exp_lat; logic [63:0] res, exp;
        logic [31:0] a, b; logic s;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            exp     = ref_div(a, b, s);
            exp_lat = (b == 32'd0) ? 2 : 33;
            run_op(a, b, s, first, nrdy, res);
            n_checks++; if (first !== exp_lat || nrdy !== 1) begin n_errors++; $display("FAIL rand_timing %0d: got first=%0d n=%0d expected %0d 1", i, first, nrdy, exp_lat); end
            n_checks++; if (res !== exp) begin n_errors++; $display("FAIL rand_result %0d (%h/%h s=%b): got %h expected %h", i, a, b, s, res, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow_dz();
        test_annul();
        test_stall();
        test_back_to_back();
        test_abort_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
